// File: rtl/pcs_rx_comma_align.sv
// pcs_rx_comma_align
// Receive-side serial-to-parallel stage of the 1000BASE-X PCS. Serial bits
// arrive on rxp, first-transmitted bit first. Comma detection sets the 10-bit
// group boundary, and a small LOS/ACQ/SYNC state machine freezes that boundary
// once lock is acquired.
// Bit ordering: code_group[0] is the first bit received (bit 'a' of abcdeifghj).
// Optional feature: define PCS_COMMA_BOTH_POL_EN to also recognise the RD+ comma
// (1100000) alongside the RD- comma (0011111).
module pcs_rx_comma_align #(
  parameter int unsigned SYNC_COMMAS  = 3,
  parameter int unsigned LOS_MISALIGN = 4
) (
  input  logic       clk,
  input  logic       mr_main_reset_n,
  input  logic       rxp,
  input  logic       signal_detect,
  output logic [9:0] code_group,
  output logic       code_valid,
  output logic       comma_det,
  output logic       realign,
  output logic       sync_status
);

  localparam int unsigned ACQ_W = (SYNC_COMMAS < 2)  ? 1 : $clog2(SYNC_COMMAS + 1);
  localparam int unsigned MIS_W = (LOS_MISALIGN < 2) ? 1 : $clog2(LOS_MISALIGN + 1);

  // Comma patterns in receive order, stored LSB-first (bit 0 = oldest bit).
  localparam logic [6:0] COMMA_NEG = 7'b1111100;  // 0011111 as received
  localparam logic [6:0] COMMA_POS = 7'b0000011;  // 1100000 as received

  typedef enum logic [1:0] {
    ST_LOS,
    ST_ACQ,
    ST_SYNC
  } state_e;

  state_e           state_q, state_d;
  // Only the newest nine bits are kept; the oldest bit of the 10-bit window
  // exists only combinationally in sr_d.
  logic [8:0]       sr_q;
  logic [9:0]       sr_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [ACQ_W-1:0] acq_cnt_q, acq_cnt_d, acq_inc;
  logic [MIS_W-1:0] mis_cnt_q, mis_cnt_d, mis_inc;
  logic [9:0]       code_group_q, code_group_d;
  logic             code_valid_q, code_valid_d;
  logic             comma_det_q, comma_det_d;
  logic             realign_q, realign_d;
  logic             sync_q, sync_d;

  logic             comma;
  logic             at_bound;
  logic             aligned;
  logic             misaligned;
  logic             do_realign;
  logic             emit;

  // Window of the ten most recent bits and comma match on its oldest seven.
  always_comb begin
    sr_d = {rxp, sr_q};
`ifdef PCS_COMMA_BOTH_POL_EN
    comma = (sr_d[6:0] == COMMA_NEG) || (sr_d[6:0] == COMMA_POS);
`else
    comma = (sr_d[6:0] == COMMA_NEG);
`endif
    at_bound   = (bitcnt_q == 4'd9);
    aligned    = comma && at_bound;
    misaligned = comma && !at_bound;
    acq_inc    = acq_cnt_q + 1'b1;
    mis_inc    = mis_cnt_q + 1'b1;
  end

  // Next-state, counter and emission decisions for the sync state machine.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = at_bound ? '0 : bitcnt_q + 4'd1;
    acq_cnt_d    = acq_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    code_group_d = code_group_q;
    code_valid_d = 1'b0;
    comma_det_d  = 1'b0;
    realign_d    = 1'b0;
    do_realign   = 1'b0;
    emit         = 1'b0;

    if (!signal_detect) begin
      // Signal loss outranks everything, including a comma in this cycle.
      state_d   = ST_LOS;
      bitcnt_d  = '0;
      acq_cnt_d = '0;
      mis_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_LOS: begin
          if (comma) begin
            do_realign = 1'b1;
            acq_cnt_d  = ACQ_W'(1);
            mis_cnt_d  = '0;
            state_d    = (SYNC_COMMAS <= 1) ? ST_SYNC : ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (misaligned) begin
            do_realign = 1'b1;
            acq_cnt_d  = ACQ_W'(1);
          end else begin
            emit = at_bound;
            if (aligned) begin
              acq_cnt_d = acq_inc;
              if (acq_inc >= ACQ_W'(SYNC_COMMAS)) begin
                state_d   = ST_SYNC;
                mis_cnt_d = '0;
              end
            end
          end
        end
        ST_SYNC: begin
          // Boundary is frozen: misaligned commas are counted, never followed.
          if (misaligned) begin
            mis_cnt_d = mis_inc;
            if (mis_inc >= MIS_W'(LOS_MISALIGN)) begin
              state_d   = ST_LOS;
              mis_cnt_d = '0;
              acq_cnt_d = '0;
            end
          end else begin
            emit = at_bound;
            if (aligned) begin
              mis_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_LOS;
        end
      endcase
    end

    if (do_realign) begin
      emit      = 1'b1;
      bitcnt_d  = '0;
      realign_d = 1'b1;
    end

    if (emit) begin
      code_group_d = sr_d;
      code_valid_d = 1'b1;
      comma_det_d  = comma;
    end

    sync_d = (state_d == ST_SYNC);
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state_q      <= ST_LOS;
      sr_q         <= '0;
      bitcnt_q     <= '0;
      acq_cnt_q    <= '0;
      mis_cnt_q    <= '0;
      code_group_q <= '0;
      code_valid_q <= 1'b0;
      comma_det_q  <= 1'b0;
      realign_q    <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d[9:1];
      bitcnt_q     <= bitcnt_d;
      acq_cnt_q    <= acq_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      code_group_q <= code_group_d;
      code_valid_q <= code_valid_d;
      comma_det_q  <= comma_det_d;
      realign_q    <= realign_d;
      sync_q       <= sync_d;
    end
  end

  assign code_group  = code_group_q;
  assign code_valid  = code_valid_q;
  assign comma_det   = comma_det_q;
  assign realign     = realign_q;
  assign sync_status = sync_q;

endmodule

// File: tb/tb_pcs_rx_comma_align.sv
// Testbench for pcs_rx_comma_align: table of transmitted bit chunks with the
// expected emissions per chunk, plus a hand-written async-reset sequence.
module tb_pcs_rx_comma_align;

`ifdef PCS_COMMA_BOTH_POL_EN
  localparam logic BOTH = 1'b1;
`else
  localparam logic BOTH = 1'b0;
`endif

  // Groups written in transmit order: MSB is the first bit on the wire.
  localparam logic [9:0] K_N  = 10'b0011111010;  // K28.5 RD-
  localparam logic [9:0] K_P  = 10'b1100000101;  // K28.5 RD+
  localparam logic [9:0] D_G  = 10'b1010101010;  // D21.5
  localparam logic [9:0] SLIP = 10'b0001111101;  // one-bit-late window of K28.5-

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxp;
  logic       signal_detect;
  logic [9:0] code_group;
  logic       code_valid;
  logic       comma_det;
  logic       realign;
  logic       sync_status;

  int total = 0;
  int bad   = 0;

  int         nv;
  int         ra_n;
  logic [9:0] last_grp;
  logic       last_cd;

  typedef struct {
    logic [9:0] tx;     // bits to send, transmit order, MSB first
    int         nb;     // number of bits of tx sent (from the MSB)
    logic       sd;     // signal_detect during the chunk
    int         ev;     // expected code_valid strobes
    logic [9:0] eg;     // expected last group (transmit order)
    logic       ecd;    // expected comma_det on last strobe
    int         era;    // expected realign pulses
    logic       esync;  // expected sync_status after the chunk
  } vec_t;

  vec_t tbl[$];

  pcs_rx_comma_align #(
    .SYNC_COMMAS (3),
    .LOS_MISALIGN(4)
  ) dut (
    .clk            (clk),
    .mr_main_reset_n(rst_n),
    .rxp            (rxp),
    .signal_detect  (signal_detect),
    .code_group     (code_group),
    .code_valid     (code_valid),
    .comma_det      (comma_det),
    .realign        (realign),
    .sync_status    (sync_status)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", name, row, got, exp);
    end
  endtask

  // Called at posedge+1: drive the bit, sample outputs 1 time unit after the edge.
  task automatic send_bit(input logic b);
    rxp = b;
    @(posedge clk);
    #1;
    if (code_valid) begin
      nv++;
      last_grp = code_group;
      last_cd  = comma_det;
    end
    if (realign) begin
      ra_n++;
      check("realign_with_valid", -1, 32'(code_valid), 32'd1);
    end
  endtask

  task automatic run_row(input int i);
    vec_t v;
    v = tbl[i];
    signal_detect = v.sd;
    nv   = 0;
    ra_n = 0;
    for (int k = 0; k < v.nb; k++) send_bit(v.tx[9-k]);
    check("valid_count", i, 32'(nv), 32'(v.ev));
    check("realign_count", i, 32'(ra_n), 32'(v.era));
    check("sync_status", i, 32'(sync_status), 32'(v.esync));
    if (v.ev > 0) begin
      check("code_group", i, 32'(last_grp), 32'(rev10(v.eg)));
      check("comma_det", i, 32'(last_cd), 32'(v.ecd));
    end
  endtask

  task automatic add(input logic [9:0] tx, input int nb, input logic sd, input int ev,
                     input logic [9:0] eg, input logic ecd, input int era,
                     input logic esync);
    vec_t v;
    v.tx = tx; v.nb = nb; v.sd = sd; v.ev = ev;
    v.eg = eg; v.ecd = ecd; v.era = era; v.esync = esync;
    tbl.push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_code_group"}, -1, 32'(code_group), 32'd0);
    check({name, "_code_valid"}, -1, 32'(code_valid), 32'd0);
    check({name, "_comma_det"}, -1, 32'(comma_det), 32'd0);
    check({name, "_realign"}, -1, 32'(realign), 32'd0);
    check({name, "_sync_status"}, -1, 32'(sync_status), 32'd0);
  endtask

  initial begin
    // Lock from reset: 3 garbage bits, then K28.5- repeated
    add(10'b1010000000, 3, 1'b1, 0, 10'b0, 1'b0, 0, 1'b0);   // 0
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 1, 1'b0);               // 1 realign, acq1
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, 1'b0);               // 2 acq2
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, 1'b1);               // 3 sync
    add(D_G, 10, 1'b1, 1, D_G, 1'b0, 0, 1'b1);               // 4 data
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, 1'b1);               // 5
    // Bit slip in SYNC
    add(10'b0, 1, 1'b1, 0, 10'b0, 1'b0, 0, 1'b1);            // 6 extra bit
    add(K_N, 10, 1'b1, 1, SLIP, 1'b0, 0, 1'b1);              // 7 mis1
    add(K_N, 10, 1'b1, 1, SLIP, 1'b0, 0, 1'b1);              // 8 mis2
    add(K_N, 10, 1'b1, 1, SLIP, 1'b0, 0, 1'b1);              // 9 mis3
    add(K_N, 10, 1'b1, 1, SLIP, 1'b0, 0, 1'b0);              // 10 mis4 -> LOS
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 1, 1'b0);               // 11 realign, acq1
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, 1'b0);               // 12 acq2
    // Bit slip in ACQ
    add(10'b0, 1, 1'b1, 0, 10'b0, 1'b0, 0, 1'b0);            // 13 extra bit
    add(K_N, 10, 1'b1, 2, K_N, 1'b1, 1, 1'b0);               // 14 data + realign
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, 1'b0);               // 15 acq2
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, 1'b1);               // 16 sync
    // Signal loss: last bit of a K28.5- with signal_detect low
    add(K_N, 9, 1'b1, 0, 10'b0, 1'b0, 0, 1'b1);              // 17
    add(10'b0, 1, 1'b0, 0, 10'b0, 1'b0, 0, 1'b0);            // 18 comma ignored
    add(D_G, 10, 1'b1, 0, 10'b0, 1'b0, 0, 1'b0);             // 19 no emission in LOS
    // Alternating disparity from LOS
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 1, 1'b0);               // 20 realign, acq1
    add(K_P, 10, 1'b1, 1, K_P, BOTH, 0, 1'b0);               // 21
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, BOTH);               // 22
    add(K_P, 10, 1'b1, 1, K_P, BOTH, 0, BOTH);               // 23
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 0, 1'b1);               // 24
    // After async reset mid-group: rest of the broken group, data, then a comma
    add(10'b1110100000, 6, 1'b1, 0, 10'b0, 1'b0, 0, 1'b0);   // 25
    add(D_G, 10, 1'b1, 0, 10'b0, 1'b0, 0, 1'b0);             // 26
    add(K_N, 10, 1'b1, 1, K_N, 1'b1, 1, 1'b0);               // 27

    rst_n         = 1'b0;
    rxp           = 1'b0;
    signal_detect = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2;
    rst_n = 1'b1;

    for (int i = 0; i <= 24; i++) run_row(i);

    // Async reset between clock edges, four bits into a K28.5-
    nv   = 0;
    ra_n = 0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("partial_valid_count", -1, 32'(nv), 32'd0);
    check("pre_reset_sync", -1, 32'(sync_status), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    #2;
    rst_n = 1'b1;

    for (int i = 25; i < tbl.size(); i++) run_row(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcs_rx_comma_align.md
# pcs_rx_comma_align

Receive-side serial-to-parallel stage of the 1000BASE-X PCS. It consumes the serial bit stream on `rxp`, one bit per `clk`, with the first-transmitted bit `a` first. It locates comma patterns and emits aligned 10-bit code groups in `[0:9]` = `abcdeifghj` order to the 8b/10b decoder. A small synchronization FSM reports `sync_status` and freezes alignment once lock is acquired.

## Interface
Parameters:
- `SYNC_COMMAS`, default 3: aligned commas required, counted from the realigning comma, to declare sync.
- `LOS_MISALIGN`, default 4: consecutive misaligned commas in SYNC that force loss of sync.

Ports:
- `clk`  in  1  bit clock; one serial bit is sampled per rising edge.
- `mr_main_reset_n`  in  1  asynchronous, active-low reset.
- `rxp`  in  1  serial receive bit.
- `signal_detect`  in  1  PMD signal present; when low, forces loss of sync.
- `code_group`  out  10  aligned code group `[0:9]`; bit 0 is the first bit received.
- `code_valid`  out  1  one-cycle strobe; `code_group` is valid while it is high.
- `comma_det`  out  1  high with `code_valid` when the emitted group starts with a comma.
- `realign`  out  1  one-cycle pulse when the group boundary is moved.
- `sync_status`  out  1  high while the FSM is in SYNC.

## Operation
- **Shift register.** `sr_next = {sr[1:9], rxp}` every cycle, so the oldest bit sits in `sr[0]`.
- **Comma match.** A comma is `sr_next[0:6] == 7'b0011111`, which is the only pattern matched without the macro. With the macro, `7'b1100000` also matches.
- **Boundary counter.** `bitcnt` runs 0..9 and wraps. A group is emitted when `bitcnt == 9`. Emission loads `code_group <= sr_next`, pulses `code_valid` for one cycle, and sets `comma_det` to the match result.
- **Aligned vs. misaligned comma.**
  - A comma is aligned if it matches while `bitcnt == 9`.
  - It is misaligned if it matches at any other count.
- **Realignment.** Allowed only in states LOS, ACQ1 and ACQ2. On a misaligned comma the block:
  - forces emission that cycle,
  - sets `bitcnt <= 0`,
  - pulses `realign`,
  - sets `comma_det = 1`.
- **States:**
  - **LOS.** No emission: `code_valid` stays 0 regardless of `bitcnt`. The first comma (either kind) realigns and moves to ACQ, with `acq_cnt = 1`.
  - **ACQ.** An aligned comma increments `acq_cnt`. When `acq_cnt` reaches `SYNC_COMMAS`, move to SYNC. A misaligned comma realigns and sets `acq_cnt = 1`. Emission is normal.
  - **SYNC.** No realignment.
    - A misaligned comma increments `mis_cnt` and does not emit.
    - An aligned comma clears `mis_cnt`.
    - When `mis_cnt` reaches `LOS_MISALIGN`, go to LOS.
- **`signal_detect` low.** In any state, next state is LOS and all counters are cleared. Takes priority over every other transition in the same cycle.
- **Simultaneous events.** A comma on the same cycle that `signal_detect` falls is ignored.

## Timing
- **Reset.** All outputs reset to 0: `code_group = 10'h000`, `code_valid`, `comma_det`, `realign`, `sync_status`. Also `sr = 0`, `bitcnt = 0`, state = LOS.
- **Reset deassertion.** The first sample is taken on the first rising edge after `mr_main_reset_n` rises.
- **Latency.** If bit `j` of a group is sampled at edge N, `code_valid` is high from edge N until edge N+1.
- **Realignment emission.** Emission on realignment uses the same edge as the match, and `realign` is coincident with `code_valid`.
- **Group spacing.** In steady state, `code_valid` is high exactly 1 cycle in 10.
- **Synchronous outputs.** `sync_status` rises and falls on the edge of the state change, not combinationally.
- **Reset mid-group.** Discards partial bits; the next group is emitted only after a fresh comma.

## Configuration
- Macro: `PCS_COMMA_BOTH_POL_EN`.
- **Defined.** Both the RD− comma `0011111` and the RD+ comma `1100000` are detected, aligned on, and counted.
- **Undefined.**
  - Only `0011111` is recognized.
  - `1100000` is treated as ordinary data, so it neither realigns nor counts.
  - All other behaviour is identical.

## Test plan
- **Lock from reset.** Reset, then a stream of K28.5− (`0011111010`) repeated with 3 bits of lead-in garbage.
  - Required: `realign` pulses once.
  - `code_group = 10'b0011111010` with `comma_det = 1` every 10 cycles.
  - `sync_status` rises at the 3rd comma.
- **Alternating disparity.** K28.5−/K28.5+ (`1100000101`) alternating.
  - With the macro: sync at the 3rd comma.
  - Without the macro: every `1100000101` arrives in a boundary slot (data group), so the realigning comma plus the next two K28.5− (5th group) gives sync at the 5th group.
- **Bit slip in ACQ.** After 2 aligned commas, insert 1 extra bit.
  - Required: `realign` pulses, the group boundary shifts by one, `acq_cnt` restarts, and `sync_status` is delayed accordingly.
- **Bit slip in SYNC.** Insert 1 extra bit while in SYNC.
  - Required: no `realign`, and `sync_status` stays 1 through 3 misaligned commas.
  - Falls on the 4th, then the next comma realigns.
- **Signal loss.** Drop `signal_detect` for 1 cycle while in SYNC.
  - Required: `sync_status = 0` the next edge and `code_valid` stops.
  - Reacquisition needs 3 fresh commas.
- **Async reset mid-group.** Assert `mr_main_reset_n = 0` mid-group between clock edges.
  - Required: outputs go to 0 immediately without a clock.
  - After release, no `code_valid` until the first comma.
